// File: rtl/cdb_writeback_arbiter.sv
// Round-robin Common Data Bus arbiter for three FP result producers, with the
// Qi (pending producer tag) table that gates register file writeback.
module cdb_writeback_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issueValid,
  input  logic [2:0]            issueReg,
  input  logic [TAG_WIDTH-1:0]  issueTag,
  input  logic [2:0]            reqValid,
  input  logic [TAG_WIDTH-1:0]  reqTag0,
  input  logic [TAG_WIDTH-1:0]  reqTag1,
  input  logic [TAG_WIDTH-1:0]  reqTag2,
  input  logic [DATA_WIDTH-1:0] reqData0,
  input  logic [DATA_WIDTH-1:0] reqData1,
  input  logic [DATA_WIDTH-1:0] reqData2,
  output logic [2:0]            reqReady,
  output logic                  cdbValid,
  output logic [TAG_WIDTH-1:0]  cdbTag,
  output logic [DATA_WIDTH-1:0] cdbData,
  output logic                  regWriteEnable,
  output logic [2:0]            regAddress,
  output logic [DATA_WIDTH-1:0] regDataIn,
  input  logic [2:0]            statusAddr,
  output logic [TAG_WIDTH-1:0]  statusTag
);

  logic [1:0]            ptr_reg;
  logic [1:0]            ptr_next;
  logic [TAG_WIDTH-1:0]  qi_reg [1:7];
  logic [2:0]            grant;
  logic                  transfer;
  logic [TAG_WIDTH-1:0]  win_tag;
  logic [DATA_WIDTH-1:0] win_data;
  logic [7:1]            match;
  logic                  match_found;
  logic [2:0]            match_idx;

  // Search order starts at the pointer and wraps; reset blocks every grant.
  always_comb begin
    grant = 3'b000;
    if (!reset) begin
      case (ptr_reg)
        2'd0: begin
          if (reqValid[0])      grant = 3'b001;
          else if (reqValid[1]) grant = 3'b010;
          else if (reqValid[2]) grant = 3'b100;
        end
        2'd1: begin
          if (reqValid[1])      grant = 3'b010;
          else if (reqValid[2]) grant = 3'b100;
          else if (reqValid[0]) grant = 3'b001;
        end
        default: begin
          if (reqValid[2])      grant = 3'b100;
          else if (reqValid[0]) grant = 3'b001;
          else if (reqValid[1]) grant = 3'b010;
        end
      endcase
    end
  end

  assign reqReady = grant;
  assign transfer = |(grant & reqValid);

  always_comb begin
    win_tag  = '0;
    win_data = '0;
    ptr_next = ptr_reg;
    if (grant[0]) begin
      win_tag  = reqTag0;
      win_data = reqData0;
      ptr_next = 2'd1;
    end else if (grant[1]) begin
      win_tag  = reqTag1;
      win_data = reqData1;
      ptr_next = 2'd2;
    end else if (grant[2]) begin
      win_tag  = reqTag2;
      win_data = reqData2;
      ptr_next = 2'd0;
    end
  end

  // Per-register Qi entry: issue wins over a same-cycle clear.
  for (genvar gi = 1; gi <= 7; gi++) begin : g_qi
    assign match[gi] = (win_tag != '0) && (qi_reg[gi] == win_tag);

    always_ff @(posedge clock) begin
      if (reset) begin
        qi_reg[gi] <= '0;
      end else if (issueValid && (issueReg == 3'(gi))) begin
        qi_reg[gi] <= issueTag;
      end else if (transfer && match_found && (match_idx == 3'(gi))) begin
        qi_reg[gi] <= '0;
      end
    end
  end

  // Lowest matching register wins if several share a tag.
  always_comb begin
    match_found = 1'b0;
    match_idx   = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (match[i]) begin
        match_found = 1'b1;
        match_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    statusTag = '0;
    for (int i = 1; i <= 7; i++) begin
      if (statusAddr == 3'(i)) statusTag = qi_reg[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_reg        <= 2'd0;
      cdbValid       <= 1'b0;
      cdbTag         <= '0;
      cdbData        <= '0;
      regWriteEnable <= 1'b0;
      regAddress     <= 3'd0;
      regDataIn      <= '0;
    end else begin
      ptr_reg        <= ptr_next;
      cdbValid       <= transfer;
      regWriteEnable <= transfer && match_found;
      if (transfer) begin
        cdbTag  <= win_tag;
        cdbData <= win_data;
      end
      if (transfer && match_found) begin
        regAddress <= match_idx;
        regDataIn  <= win_data;
      end
    end
  end

endmodule

// File: doc/cdb_writeback_arbiter.md
# cdb_writeback_arbiter

Common Data Bus arbiter and register-result-status controller for the floating-point Tomasulo datapath. It accepts completed results from three functional units (adder, multiplier, load buffer), grants one per cycle in round-robin order, broadcasts the winner on the CDB, and drives the FP register file write port. A write happens only when the destination register's pending tag matches the broadcast tag. It also keeps the 7-entry Qi table (pending producer tag per FP register R1–R7), which the issue stage sets.

## Interface
Parameters:
- DATA_WIDTH, 16, width of result data and register file data
- TAG_WIDTH, 3, reservation-station tag width; tag 0 means "no producer / value ready"

Ports:
- clock  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- issueValid  in  1  issue stage reserves a destination register this cycle
- issueReg  in  3  destination register 1–7; 0 = no destination, ignored
- issueTag  in  TAG_WIDTH  producing reservation-station tag
- reqValid  in  3  result pending; bit0 adder, bit1 multiplier, bit2 load
- reqTag0/1/2  in  TAG_WIDTH  tag of requester 0/1/2
- reqData0/1/2  in  DATA_WIDTH  result of requester 0/1/2
- reqReady  out  3  grant, one-hot or zero; transfer when reqValid[i] & reqReady[i]
- cdbValid  out  1  CDB broadcast valid
- cdbTag  out  TAG_WIDTH  broadcast tag
- cdbData  out  DATA_WIDTH  broadcast data
- regWriteEnable  out  1  to register file writeEnable
- regAddress  out  3  to register file dataAddress
- regDataIn  out  DATA_WIDTH  to register file dataIn
- statusAddr  in  3  Qi read address
- statusTag  out  TAG_WIDTH  Qi[statusAddr]; 0 for address 0

## Operation
- Qi table: Qi[1..7], TAG_WIDTH each, all 0 at reset.
- Arbitration: a round-robin pointer P in {0,1,2} sets the search order P, P+1, P+2 (mod 3). The first requester in that order with reqValid set gets reqReady. After a transfer by requester g, P becomes (g+1) mod 3. P is unchanged when nothing is granted. P = 0 at reset.
- Requesters hold reqValid, tag and data stable until granted; deasserting before grant is legal and simply withdraws the request.
- On a transfer, at the same edge:
  - cdbValid, cdbTag and cdbData are loaded with the winner's values.
  - The winner's tag is compared against Qi[1..7]. On a match (tag ≠ 0), regWriteEnable=1, regAddress=matched index and regDataIn=data. Qi[matched] clears to 0.
  - If more than one register matches (illegal usage), the lowest index is written and cleared.
- Tag 0 result: still broadcast, with cdbValid=1; no register match, so regWriteEnable=0.
- Issue: when issueValid and issueReg≠0, Qi[issueReg] ← issueTag. Issue has priority over a same-cycle clear of the same register, so the new tag is kept. The register file write for the old tag still occurs, which is harmless because the value is superseded later.
- No transfer in a cycle: cdbValid=0 and regWriteEnable=0 on the next cycle. cdbTag, cdbData, regAddress and regDataIn hold their previous values.
- Reset:
  - Outputs: cdbValid=0, cdbTag=0, cdbData=0, regWriteEnable=0, regAddress=0, regDataIn=0.
  - State: P=0, all Qi=0.
  - reqReady is forced to 0 while reset is high.
  - Reset asserted mid-stream discards any grant in that cycle; no transfer occurs.

## Timing
- reqReady and statusTag are combinational (from reqValid, P, reset / Qi, statusAddr).
- Everything else is registered.
- Latency: a grant in cycle N produces CDB and register-file outputs in cycle N+1, held for exactly one cycle.
- The register file captures the write at the end of N+1.
- Throughput: one result per cycle; back-to-back grants give back-to-back broadcasts.
- Issue in cycle N is visible on statusTag in cycle N+1.
- A grant in cycle N compares against Qi as it stood at the start of N. A same-cycle issue to the matched register is therefore not seen by that comparison, and the issue tag is kept.

## Test plan
- Reset: assert reset 2 cycles with all reqValid=3'b111 -> reqReady=0 during reset; all outputs 0 and statusTag=0 for addresses 1–7 afterward.
- Basic writeback: issue R3 tag 5; next cycle adder requests tag 5, data 16'h4A00 -> reqReady=3'b001 that cycle. Next cycle: cdbValid=1, cdbTag=5, cdbData=16'h4A00, regWriteEnable=1, regAddress=3, regDataIn=16'h4A00. Then statusTag(3)=0.
- Round-robin: all three request continuously with distinct tags from P=0 -> grants 001, 010, 100, 001 on consecutive cycles; cdbValid stays high for 4 cycles.
- Stale tag: issue R2 tag 1, then issue R2 tag 4, then multiplier broadcasts tag 1 -> cdbValid=1, regWriteEnable=0, statusTag(2)=4.
- Simultaneous issue/clear: R6 pending tag 2; in the same cycle load is granted with tag 2 and issue R6 tag 7 -> next cycle regWriteEnable=1, regAddress=6, statusTag(6)=7.
- Tag 0 and reset mid-stream: load requests tag 0 -> cdbValid=1, regWriteEnable=0. Then reset is asserted while the adder request is pending -> no broadcast the following cycle, P=0.
